ahblite_interconnect_n: RTL and testbench
=========================================

Name: ahblite_interconnect_n

Overview:
Parametrised successor to the fixed four-port AHB-Lite interconnect between the Cortex-M0 master and its slaves (code RAM, data RAM, peripherals).
- Supports 1..8 slave ports with a parameter-driven region map.
- Adds a built-in default slave that returns a two-cycle ERROR response for unmapped transfers.
- Adds a stall watchdog that flags a slave holding HREADYOUT low too long.
- Sits between the core's AHB master port and the slave interfaces; one clock domain.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..8)
REGION_MAP, 32'h0000_5420, 4-bit nibble i is the HADDR[31:28] value decoded to slave i (default: S0=0x0, S1=0x2, S2=0x4, S3=0x5)
TIMEOUT_CYCLES, 16'd1024, stall cycles before the watchdog fires; 0 disables the watchdog

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  synchronous active-low reset
HADDR  in  32  master address
HTRANS  in  2  master transfer type
HWRITE  in  1  master write
HSIZE  in  3  master size
HBURST  in  3  master burst
HPROT  in  4  master protection
HMASTLOCK  in  1  master lock
HWDATA  in  32  master write data
HRDATA  out  32  read data to master
HREADY  out  1  ready to master; also broadcast to slaves
HRESP  out  1  response to master
HSEL_S  out  NUM_SLAVES  per-slave select
HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S, HMASTLOCK_S, HWDATA_S  out  as master  broadcast copies of the master signals
HREADYOUT_S  in  NUM_SLAVES  per-slave ready
HRESP_S  in  NUM_SLAVES  per-slave response
HRDATA_S  in  32*NUM_SLAVES  per-slave read data; slave i occupies bits [32i+31:32i]
TIMEOUT_FLAG  out  1  sticky watchdog flag
TIMEOUT_SLV  out  3  index of the stalled slave
TIMEOUT_CLR  in  1  clears TIMEOUT_FLAG

Behaviour:
Clock/reset:
- One clock, HCLK.
- Reset is synchronous and active-low (HRESETn sampled on the rising edge of HCLK).

Address-phase decode (combinational):
- HSEL_S[i] = (HADDR[31:28] == REGION_MAP[4i+3:4i]), independent of HTRANS.
- Duplicate nibbles: the lowest index wins; only one HSEL_S bit is ever high.
- No match selects the internal default slave.
- Broadcast outputs are wire copies of the master signals.

Data-phase select register dsel (NUM_SLAVES+1 states, one-hot or encoded):
- Loads the decoded target only when HREADY=1.
- Reset value is "default slave, idle".

Output mux:
- Real slave selected: HREADY/HRESP/HRDATA = that slave's HREADYOUT_S/HRESP_S/HRDATA_S.
- Default slave selected: HRDATA=0.
- Reset values: HREADY=1, HRESP=0, HRDATA=0, TIMEOUT_FLAG=0, TIMEOUT_SLV=0.

Default-slave FSM, states IDLE, ERR1, ERR2:
- IDLE: HREADY=1, HRESP=0. Moves to ERR1 when the default slave is decoded, HTRANS[1]=1 (NONSEQ/SEQ) and HREADY=1.
- ERR1: HREADY=0, HRESP=1. Always moves to ERR2.
- ERR2: HREADY=1, HRESP=1. Moves to ERR1 if another unmapped NONSEQ/SEQ is in address phase, else IDLE.
- IDLE/BUSY to an unmapped region: zero-wait OKAY.

Watchdog:
- 16-bit counter increments each cycle with HREADY=0 while a real slave owns the data phase.
- Counter clears when HREADY=1; it saturates.
- When the counter equals TIMEOUT_CYCLES (nonzero): TIMEOUT_FLAG<=1 and TIMEOUT_SLV<=dsel index.
- No bus action is taken; the master stays stalled.
- TIMEOUT_FLAG clears on TIMEOUT_CLR=1. If set and clear occur in the same cycle, set wins.
- TIMEOUT_SLV holds its value until the next fire.

Boundaries:
- Reset asserted mid-transfer: next edge forces dsel to default-idle, FSM to IDLE, counter and flag to 0.
- Back-to-back slave switches (S0 then S2) need zero extra cycles; the mux follows dsel.
- NUM_SLAVES=1 is legal.
- Unused REGION_MAP nibbles above NUM_SLAVES are ignored.

Test Plan:
- Read 0x2000_0010 (S1 returns 0xDEAD_BEEF, zero wait) -> HSEL_S=4'b0010 in address phase; HRDATA=0xDEAD_BEEF, HREADY=1, HRESP=0 in the next cycle.
- NONSEQ write to 0x9000_0000 -> cycle 1: HREADY=0, HRESP=1; cycle 2: HREADY=1, HRESP=1; no HSEL_S bit set. The same access with HTRANS=IDLE -> OKAY, zero wait.
- Back-to-back NONSEQ S0 then S2 with S0 inserting 2 wait states -> S2's address phase is held; S2 data is returned on the cycle after S0 completes.
- TIMEOUT_CYCLES=8, S3 holds HREADYOUT low for 20 cycles -> TIMEOUT_FLAG rises after 8 stall cycles, TIMEOUT_SLV=3. TIMEOUT_CLR pulse afterwards -> flag=0. TIMEOUT_CLR coincident with a fire -> flag stays 1.
- HRESETn low during ERR1 -> next cycle HREADY=1, HRESP=0, HRDATA=0, FSM in IDLE.
- REGION_MAP with S1 and S3 both 0x2 -> access to 0x2xxx_xxxx selects only S1.

Source files
------------

// File: rtl/ahblite_interconnect_n.sv
// ahblite_interconnect_n
//
// AHB-Lite interconnect between one master (Cortex-M0) and 1..8 slaves.
// The address phase is decoded combinationally from HADDR[31:28] against a
// nibble-per-slave region map. The data-phase owner is registered in dsel.
// A built-in default slave answers unmapped active transfers with a
// two-cycle ERROR response. A watchdog flags a slave that holds HREADYOUT
// low for TIMEOUT_CYCLES cycles. The watchdog only reports the stall; it
// takes no action on the bus.
//
// Handshake: an address phase is accepted on a rising HCLK edge where
// HREADY=1. The data phase of that transfer then completes on the first
// later edge where HREADY=1. HREADY is broadcast to every slave.
//
// Ports:
//   HCLK, HRESETn        clock and synchronous active-low reset
//   HADDR..HWDATA        master address/control/write data
//   HRDATA/HREADY/HRESP  muxed response to the master
//   HSEL_S               one-hot slave select (address phase)
//   H*_S (outputs)       broadcast copies of the master signals
//   HREADYOUT_S/HRESP_S/HRDATA_S  per-slave responses; slave i data is at
//                        bits [32i+31:32i]
//   TIMEOUT_FLAG/SLV     sticky watchdog flag and index of the stalled slave
//   TIMEOUT_CLR          clears TIMEOUT_FLAG
//   dflt_state           debug view of the default-slave FSM
//                        (0 IDLE, 1 ERR1, 2 ERR2)
module ahblite_interconnect_n #(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [31:0] REGION_MAP     = 32'h0000_5420,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [3:0]               HPROT,
    input  logic                     HMASTLOCK,
    input  logic [31:0]              HWDATA,
    output logic [31:0]              HRDATA,
    output logic                     HREADY,
    output logic                     HRESP,
    output logic [NUM_SLAVES-1:0]    HSEL_S,
    output logic [31:0]              HADDR_S,
    output logic [1:0]               HTRANS_S,
    output logic                     HWRITE_S,
    output logic [2:0]               HSIZE_S,
    output logic [2:0]               HBURST_S,
    output logic [3:0]               HPROT_S,
    output logic                     HMASTLOCK_S,
    output logic [31:0]              HWDATA_S,
    input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]    HRESP_S,
    input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
    output logic                     TIMEOUT_FLAG,
    output logic [2:0]               TIMEOUT_SLV,
    input  logic                     TIMEOUT_CLR,
    output logic [1:0]               dflt_state
);

    // Index NUM_SLAVES encodes the internal default slave.
    localparam int SW = $clog2(NUM_SLAVES + 1);
    localparam logic [SW-1:0] DFLT_IDX = SW'(NUM_SLAVES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dflt_state_t;

    dflt_state_t     state;
    logic            dflt_ready;
    logic            dflt_resp;
    logic [SW-1:0]   dec_idx;
    logic            dflt_hit;
    logic [SW-1:0]   dsel;
    logic            dsel_real;
    logic [2:0]      dsel_slv;
    logic [15:0]     wd_cnt;
    logic [15:0]     wd_inc;
    logic            wd_stall;
    logic            wd_fire;

    // Broadcast copies of the master signals.
    assign HADDR_S     = HADDR;
    assign HTRANS_S    = HTRANS;
    assign HWRITE_S    = HWRITE;
    assign HSIZE_S     = HSIZE;
    assign HBURST_S    = HBURST;
    assign HPROT_S     = HPROT;
    assign HMASTLOCK_S = HMASTLOCK;
    assign HWDATA_S    = HWDATA;

    assign dflt_state  = state;

    // Address decode. The loop scans downwards so the lowest matching index
    // is written last and wins when region nibbles are duplicated.
    always_comb begin
        dec_idx = DFLT_IDX;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (HADDR[31:28] == REGION_MAP[4*i +: 4]) begin
                dec_idx = SW'(i);
            end
        end
        HSEL_S = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dec_idx == SW'(i)) begin
                HSEL_S[i] = 1'b1;
            end
        end
    end

    assign dflt_hit = (dec_idx == DFLT_IDX);

    // Response mux driven by the data-phase owner.
    always_comb begin
        HREADY    = dflt_ready;
        HRESP     = dflt_resp;
        HRDATA    = '0;
        dsel_real = 1'b0;
        dsel_slv  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel == SW'(i)) begin
                HREADY    = HREADYOUT_S[i];
                HRESP     = HRESP_S[i];
                HRDATA    = HRDATA_S[32*i +: 32];
                dsel_real = 1'b1;
                dsel_slv  = 3'(i);
            end
        end
    end

    // Data-phase owner advances only when the previous transfer completes.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dsel <= DFLT_IDX;
        end else if (HREADY) begin
            dsel <= dec_idx;
        end
    end

    // Default slave: two-cycle ERROR for unmapped NONSEQ/SEQ transfers.
    // The outputs are registered alongside the state so that they line up
    // with it.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            dflt_ready <= 1'b1;
            dflt_resp  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dflt_hit && HTRANS[1] && HREADY) begin
                        state      <= ST_ERR1;
                        dflt_ready <= 1'b0;
                        dflt_resp  <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state      <= ST_ERR2;
                    dflt_ready <= 1'b1;
                    dflt_resp  <= 1'b1;
                end
                ST_ERR2: begin
                    if (dflt_hit && HTRANS[1]) begin
                        state      <= ST_ERR1;
                        dflt_ready <= 1'b0;
                        dflt_resp  <= 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        dflt_ready <= 1'b1;
                        dflt_resp  <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    dflt_ready <= 1'b1;
                    dflt_resp  <= 1'b0;
                end
            endcase
        end
    end

    // Watchdog. The fire test uses the incremented count, so the flag is
    // visible right after the TIMEOUT_CYCLES-th stalled edge.
    assign wd_inc   = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;
    assign wd_stall = !HREADY && dsel_real;
    assign wd_fire  = wd_stall && (TIMEOUT_CYCLES != 16'd0) && (wd_inc == TIMEOUT_CYCLES);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wd_cnt       <= '0;
            TIMEOUT_FLAG <= 1'b0;
            TIMEOUT_SLV  <= '0;
        end else begin
            if (HREADY) begin
                wd_cnt <= '0;
            end else if (wd_stall) begin
                wd_cnt <= wd_inc;
            end
            // When a fire and a clear happen in the same cycle, the fire wins.
            if (wd_fire) begin
                TIMEOUT_FLAG <= 1'b1;
                TIMEOUT_SLV  <= dsel_slv;
            end else if (TIMEOUT_CLR) begin
                TIMEOUT_FLAG <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahblite_interconnect_n.sv
// Directed bench for ahblite_interconnect_n: decode, default-slave error
// response, wait-state pipelining, watchdog, reset during an error, and
// duplicate region map entries.
module tb_ahblite_interconnect_n;

  // ---------------- clock / reset ----------------
  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [2:0]   hburst;
  logic [3:0]   hprot;
  logic         hmastlock;
  logic [31:0]  hwdata;
  logic [3:0]   hreadyout_s;
  logic [3:0]   hresp_s;
  logic [127:0] hrdata_s;
  logic         timeout_clr;

  logic [31:0]  hrdata;
  logic         hready;
  logic         hresp;
  logic [3:0]   hsel_s;
  logic [31:0]  haddr_s;
  logic [1:0]   htrans_s;
  logic         hwrite_s;
  logic [2:0]   hsize_s;
  logic [2:0]   hburst_s;
  logic [3:0]   hprot_s;
  logic         hmastlock_s;
  logic [31:0]  hwdata_s;
  logic         timeout_flag;
  logic [2:0]   timeout_slv;
  logic [1:0]   dflt_state;

  logic [31:0]  dup_hrdata;
  logic         dup_hready;
  logic         dup_hresp;
  logic [3:0]   dup_hsel_s;
  logic [31:0]  dup_haddr_s;
  logic [1:0]   dup_htrans_s;
  logic         dup_hwrite_s;
  logic [2:0]   dup_hsize_s;
  logic [2:0]   dup_hburst_s;
  logic [3:0]   dup_hprot_s;
  logic         dup_hmastlock_s;
  logic [31:0]  dup_hwdata_s;
  logic         dup_timeout_flag;
  logic [2:0]   dup_timeout_slv;
  logic [1:0]   dup_dflt_state;

  ahblite_interconnect_n #(
    .NUM_SLAVES(4), .REGION_MAP(32'h0000_5420), .TIMEOUT_CYCLES(16'd8)
  ) u_dut (
    .HCLK(hclk), .HRESETn(hresetn),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .HSEL_S(hsel_s),
    .HADDR_S(haddr_s), .HTRANS_S(htrans_s), .HWRITE_S(hwrite_s),
    .HSIZE_S(hsize_s), .HBURST_S(hburst_s), .HPROT_S(hprot_s),
    .HMASTLOCK_S(hmastlock_s), .HWDATA_S(hwdata_s),
    .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
    .TIMEOUT_FLAG(timeout_flag), .TIMEOUT_SLV(timeout_slv),
    .TIMEOUT_CLR(timeout_clr), .dflt_state(dflt_state)
  );

  // S1 and S3 both map to 0x2; S1 must win.
  ahblite_interconnect_n #(
    .NUM_SLAVES(4), .REGION_MAP(32'h0000_2420), .TIMEOUT_CYCLES(16'd8)
  ) u_dup (
    .HCLK(hclk), .HRESETn(hresetn),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
    .HRDATA(dup_hrdata), .HREADY(dup_hready), .HRESP(dup_hresp),
    .HSEL_S(dup_hsel_s), .HADDR_S(dup_haddr_s), .HTRANS_S(dup_htrans_s),
    .HWRITE_S(dup_hwrite_s), .HSIZE_S(dup_hsize_s), .HBURST_S(dup_hburst_s),
    .HPROT_S(dup_hprot_s), .HMASTLOCK_S(dup_hmastlock_s),
    .HWDATA_S(dup_hwdata_s),
    .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
    .TIMEOUT_FLAG(dup_timeout_flag), .TIMEOUT_SLV(dup_timeout_slv),
    .TIMEOUT_CLR(timeout_clr), .dflt_state(dup_dflt_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after a rising edge; checks follow a further 1 ns
  // settle, well clear of the next edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [1:0] t, input logic w);
    haddr  = a;
    htrans = t;
    hwrite = w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hresetn     = 1'b0;
    haddr       = '0;
    htrans      = 2'b00;
    hwrite      = 1'b0;
    hsize       = 3'b010;
    hburst      = 3'b000;
    hprot       = 4'b0011;
    hmastlock   = 1'b0;
    hwdata      = 32'hA5A5_5A5A;
    hreadyout_s = 4'hF;
    hresp_s     = 4'h0;
    hrdata_s    = '0;
    timeout_clr = 1'b0;

    // Reset state
    tick(2);
    check("rst_hready", 32'(hready), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_flag", 32'(timeout_flag), 32'd0);
    check("rst_slv", 32'(timeout_slv), 32'd0);
    check("rst_state", 32'(dflt_state), 32'd0);
    hresetn = 1'b1;
    tick(1);

    // Read from S1, zero wait states
    addr_phase(32'h2000_0010, 2'b10, 1'b0);
    settle();
    check("s1_hsel", 32'(hsel_s), 32'h2);
    check("s1_haddr_bcast", haddr_s, 32'h2000_0010);
    check("s1_hwdata_bcast", hwdata_s, 32'hA5A5_5A5A);
    check("dup_hsel_s1", 32'(dup_hsel_s), 32'h2);
    tick(1);
    addr_phase(32'h0000_0000, 2'b00, 1'b0);
    hrdata_s[32 +: 32] = 32'hDEAD_BEEF;
    settle();
    check("s1_hrdata", hrdata, 32'hDEAD_BEEF);
    check("s1_hready", 32'(hready), 32'd1);
    check("s1_hresp", 32'(hresp), 32'd0);
    hresp_s[1] = 1'b1;
    settle();
    check("s1_hresp_pass", 32'(hresp), 32'd1);
    hresp_s[1] = 1'b0;
    tick(1);

    // Unmapped NONSEQ write -> two-cycle ERROR
    addr_phase(32'h9000_0000, 2'b10, 1'b1);
    settle();
    check("unmap_hsel", 32'(hsel_s), 32'h0);
    tick(1);
    addr_phase(32'h0000_0000, 2'b00, 1'b0);
    settle();
    check("err1_hready", 32'(hready), 32'd0);
    check("err1_hresp", 32'(hresp), 32'd1);
    tick(1);
    check("err2_hready", 32'(hready), 32'd1);
    check("err2_hresp", 32'(hresp), 32'd1);
    tick(1);
    check("err_done_hresp", 32'(hresp), 32'd0);
    check("err_done_state", 32'(dflt_state), 32'd0);

    // Same unmapped address but IDLE -> OKAY, zero wait
    addr_phase(32'h9000_0000, 2'b00, 1'b1);
    tick(1);
    check("unmap_idle_hready", 32'(hready), 32'd1);
    check("unmap_idle_hresp", 32'(hresp), 32'd0);
    check("unmap_idle_state", 32'(dflt_state), 32'd0);

    // Back-to-back S0 (2 wait states) then S2
    addr_phase(32'h0000_0100, 2'b10, 1'b0);
    settle();
    check("s0_hsel", 32'(hsel_s), 32'h1);
    tick(1);
    addr_phase(32'h4000_0000, 2'b10, 1'b0);
    hreadyout_s[0] = 1'b0;
    settle();
    check("s0_wait1_hready", 32'(hready), 32'd0);
    check("s2_hsel_held", 32'(hsel_s), 32'h4);
    check("dup_hsel_s2", 32'(dup_hsel_s), 32'h4);
    tick(1);
    check("s0_wait2_hready", 32'(hready), 32'd0);
    tick(1);
    hreadyout_s[0] = 1'b1;
    hrdata_s[0 +: 32] = 32'h1111_0000;
    settle();
    check("s0_done_hready", 32'(hready), 32'd1);
    check("s0_hrdata", hrdata, 32'h1111_0000);
    tick(1);
    addr_phase(32'h0000_0000, 2'b00, 1'b0);
    hrdata_s[64 +: 32] = 32'h2222_0002;
    settle();
    check("s2_hrdata", hrdata, 32'h2222_0002);
    check("s2_hready", 32'(hready), 32'd1);
    check("s0_short_no_flag", 32'(timeout_flag), 32'd0);
    tick(1);

    // Watchdog: S3 stalls for 20 cycles
    addr_phase(32'h5000_0000, 2'b10, 1'b0);
    tick(1);
    addr_phase(32'h0000_0000, 2'b00, 1'b0);
    hreadyout_s[3] = 1'b0;
    tick(7);
    check("wd_before_fire", 32'(timeout_flag), 32'd0);
    tick(1);
    check("wd_fire_flag", 32'(timeout_flag), 32'd1);
    check("wd_fire_slv", 32'(timeout_slv), 32'd3);
    tick(1);
    timeout_clr = 1'b1;
    tick(1);
    timeout_clr = 1'b0;
    check("wd_clr_flag", 32'(timeout_flag), 32'd0);
    check("wd_slv_hold", 32'(timeout_slv), 32'd3);
    tick(10);
    check("wd_no_refire", 32'(timeout_flag), 32'd0);
    hreadyout_s[3] = 1'b1;
    tick(1);

    // Watchdog: clear coincident with fire -> set wins
    addr_phase(32'h5000_0000, 2'b10, 1'b0);
    tick(1);
    addr_phase(32'h0000_0000, 2'b00, 1'b0);
    hreadyout_s[3] = 1'b0;
    tick(7);
    timeout_clr = 1'b1;
    tick(1);
    timeout_clr = 1'b0;
    check("wd_set_wins", 32'(timeout_flag), 32'd1);
    hreadyout_s[3] = 1'b1;
    tick(1);

    // Reset asserted during ERR1
    addr_phase(32'h9000_0000, 2'b10, 1'b0);
    tick(1);
    addr_phase(32'h0000_0000, 2'b00, 1'b0);
    settle();
    check("pre_rst_err1", 32'(dflt_state), 32'd1);
    hresetn = 1'b0;
    tick(1);
    check("rst_err1_hready", 32'(hready), 32'd1);
    check("rst_err1_hresp", 32'(hresp), 32'd0);
    check("rst_err1_hrdata", hrdata, 32'd0);
    check("rst_err1_state", 32'(dflt_state), 32'd0);
    check("rst_err1_flag", 32'(timeout_flag), 32'd0);
    hresetn = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
